uart_rx_param: RTL and testbench

Parametrised UART receiver; successor to the fixed 11-bit receive block.
Configurable data width, oversampling ratio, parity mode and stop-bit count. Samples at mid-bit, validates the start bit and reports parity and framing errors.
Sits behind the APB interface block, using the same rxStart / store / clrRxStartBit handshake. An external baud-tick generator gates sampling.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 24 ++
 rtl/uart_rx_param.sv | 109 ++++++++++
 tb/tb_uart_rx_param.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, defaults and helpers shared by the UART receiver and transmitter
package uart_pkg;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5,
    S_CLEAR  = 3'd6
  } state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: oversample tick counter with mid-bit and sample-point strobes
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic clr_i,
  output logic mid_o,
  output logic smp_o
);
  localparam int TW = clog2(OVERSAMPLE);
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  assign mid_o = tick_i && tick_cnt_q == TW'(OVERSAMPLE / 2 - 1);
  assign smp_o = tick_i && tick_cnt_q == TW'(OVERSAMPLE - 1);
  // clear wins; otherwise advance on ticks and wrap naturally at OVERSAMPLE
  always_comb tick_cnt_d = clr_i ? '0 : tick_cnt_q + TW'(tick_i);
  // tick counter register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_d;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling, parity and framing checks
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sample_tick_i,
  input  logic                 rx_start_i,
  input  logic                 rx_d_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 store_o,
  output logic                 clr_rx_start_bit_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o
);
  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, rx_data_q;
  logic                 par_q, par_d, frm_q, frm_d;
  logic                 parity_err_q, frame_err_q;
  logic                 load, mid, smp, clr, rxd;
  assign rxd                = sync_q[1];
  assign clr                = state_q == S_IDLE || (state_q == S_START && mid);
  assign rx_data_o          = rx_data_q;
  assign parity_err_o       = parity_err_q;
  assign frame_err_o        = frame_err_q;
  assign store_o            = state_q == S_DONE;
  assign clr_rx_start_bit_o = state_q == S_CLEAR;
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_i (sample_tick_i),
    .clr_i  (clr),
    .mid_o  (mid),
    .smp_o  (smp)
  );
  // frame sequencing; a dropped rxStart abandons any frame in flight without touching outputs
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    frm_d     = frm_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: state_d = rx_start_i && !rxd ? S_START : S_IDLE;
      S_START: if (mid) begin
        state_d   = rxd ? S_IDLE : S_DATA;
        bit_cnt_d = '0;
        par_d     = 1'b0;
        frm_d     = 1'b0;
      end
      S_DATA: if (smp) begin
        shreg_d   = {rxd, shreg_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q == 4'(DATA_BITS - 1) ? 4'd0 : bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = PARITY_EN != 0 ? S_PARITY : S_STOP;
      end
      S_PARITY: if (smp) begin
        par_d     = ^shreg_q ^ rxd ^ 1'(PARITY_ODD);
        bit_cnt_d = '0;
        state_d   = S_STOP;
      end
      S_STOP: if (smp) begin
        frm_d     = frm_q | ~rxd;
        bit_cnt_d = bit_cnt_q + 4'd1;
        load      = bit_cnt_q == 4'(STOP_BITS - 1);
        state_d   = load ? S_DONE : S_STOP;
      end
      S_DONE: state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
    if (!rx_start_i && state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
      state_d = S_IDLE;
      load    = 1'b0;
    end
  end
  // synchroniser, FSM state and result registers; results load only on entry to DONE
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      frm_q        <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_d_i};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      frm_q     <= frm_d;
      if (load) begin
        rx_data_q    <= shreg_q;
        parity_err_q <= par_q;
        frame_err_q  <= frm_d;
      end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: random and directed frames on two receiver configurations against a frame-level model
module tb_uart_rx_param;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start_a = 1'b1, start_b = 1'b1, rxd_a = 1'b1, rxd_b = 1'b1, tick_b;
  logic [1:0] div = 2'd0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       store_a, store_b, clr_a, clr_b, perr_a, perr_b, ferr_a, ferr_b;
  int         total = 0, bad = 0, fno = 0;
  int         ld[2], lp[2], lf[2];
  always #5 clk = ~clk;
  always @(posedge clk) div <= div == 2'd2 ? 2'd0 : div + 2'd1;
  assign tick_b = div == 2'd0;
  uart_rx_param u_a (
    .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(1'b1), .rx_start_i(start_a), .rx_d_i(rxd_a),
    .rx_data_o(data_a), .store_o(store_a), .clr_rx_start_bit_o(clr_a),
    .parity_err_o(perr_a), .frame_err_o(ferr_a)
  );
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(0), .STOP_BITS(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(tick_b), .rx_start_i(start_b), .rx_d_i(rxd_b),
    .rx_data_o(data_b), .store_o(store_b), .clr_rx_start_bit_o(clr_b),
    .parity_err_o(perr_b), .frame_err_o(ferr_b)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s frame=%0d got=%0d exp=%0d", tag, fno, got, exp);
    end
  endtask
  task automatic chk_zero();
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_flags_a", int'({store_a, clr_a, perr_a, ferr_a}), 0);
    chk("rst_data_b", int'(data_b), 0);
    chk("rst_flags_b", int'({store_b, clr_b, perr_b, ferr_b}), 0);
  endtask
  // drive one frame (or a glitch / aborted frame) and compare against the frame-level expectation
  task automatic run(input bit b, input int data, input bit pbit, input int stops, input int glitch, input int abort_at);
    int nd, pen, ns, os, cpb, n, k, tc, got, exp_c, clf, n_st, n_cl;
    bit v, st, cl, tk, keep;
    logic [15:0] line;
    fno++;
    nd = b ? 7 : 8;
    pen = b ? 0 : 1;
    ns = b ? 2 : 1;
    os = b ? 8 : 16;
    cpb = b ? 24 : 16;
    line = '0;
    n = 1;
    for (int i = 0; i < nd; i++) begin line[n] = data[i]; n++; end
    if (pen != 0) begin line[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin line[n] = stops[i]; n++; end
    k = os / 2 + os * (n - 1);
    tc = 0; got = -1; exp_c = -1; clf = -1; n_st = 0; n_cl = 0;
    keep = glitch == 0 && abort_at < 0;
    for (int c = 0; c < (n + 1) * cpb; c++) begin
      @(negedge clk);
      v = glitch > 0 ? c >= glitch : (c / cpb < n ? line[c / cpb] : 1'b1);
      if (b) rxd_b = v; else rxd_a = v;
      if (c == abort_at) begin if (b) start_b = 1'b0; else start_a = 1'b0; end
      st = b ? store_b : store_a;
      cl = b ? clr_b : clr_a;
      tk = b ? tick_b : 1'b1;
      if (st) begin n_st++; if (got < 0) got = c; end
      if (cl) begin n_cl++; if (clf < 0) clf = c; end
      if (c >= 3 && tk) tc++;
      if (tc == k && exp_c < 0) exp_c = c + 1;
    end
    start_a = 1'b1;
    start_b = 1'b1;
    if (keep) begin
      ld[b] = data;
      lp[b] = (pen != 0 && ($countones(data) + int'(pbit)) % 2 != 0) ? 1 : 0;
      lf[b] = (stops & ((1 << ns) - 1)) != (1 << ns) - 1 ? 1 : 0;
    end
    chk("store_count", n_st, int'(keep));
    chk("clr_count", n_cl, int'(keep));
    if (keep) begin
      chk("store_latency", got, exp_c);
      chk("clr_after_store", clf, exp_c + 1);
    end
    chk("rx_data", b ? int'(data_b) : int'(data_a), ld[b]);
    chk("parity_err", b ? int'(perr_b) : int'(perr_a), lp[b]);
    chk("frame_err", b ? int'(ferr_b) : int'(ferr_a), lf[b]);
  endtask
  initial begin
    int d;
    bit pe;
    for (int i = 0; i < 2; i++) begin ld[i] = 0; lp[i] = 0; lf[i] = 0; end
    repeat (3) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run(0, 'h5A, 1'b0, 1, 0, -1);
    run(0, 'h5A, 1'b1, 1, 0, -1);
    run(0, 'hA5, 1'b0, 0, 0, -1);
    run(0, 0, 1'b0, 1, 4, -1);
    run(0, 'h3C, 1'b0, 1, 0, 80);
    run(1, 'h3C, 1'b0, 3, 0, -1);
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 255));
      pe = $urandom_range(0, 3) == 0;
      run(0, d, ^d[7:0] ^ pe, $urandom_range(0, 4) != 0 ? 1 : 0, 0, -1);
    end
    for (int i = 0; i < 6; i++) run(1, int'($urandom_range(0, 127)), 1'b0, int'($urandom_range(0, 3)), 0, -1);
    run(1, 0, 1'b0, 3, 6, -1);
    run(1, 'h55, 1'b0, 3, 0, 120);
    @(negedge clk);
    rxd_a = 1'b0;
    repeat (16) @(negedge clk);
    rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    fno++;
    chk_zero();
    for (int i = 0; i < 2; i++) begin ld[i] = 0; lp[i] = 0; lf[i] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run(0, 'hFF, 1'b0, 1, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
